// File: rtl/motor3_commutation_sequencer.sv
// Six-step trapezoidal commutation sequencer for a 3-phase half-bridge driver.
// Optional high-side PWM chopping during DRIVE is enabled by defining MOTOR3_PWM_EN.
module motor3_commutation_sequencer #(
  parameter int PERIOD_W = 16,
  parameter int DEAD_W   = 8
) (
  input  logic                clkI,
  input  logic                rstI,
  input  logic                enI,
  input  logic                dirI,
  input  logic                faultI,
  input  logic [PERIOD_W-1:0] stepPeriodI,
  input  logic [DEAD_W-1:0]   deadTimeI,
  input  logic [7:0]          pwmDutyI,
  output logic [1:0]          phA_down1_up2o,
  output logic [1:0]          phB_down1_up2o,
  output logic [1:0]          phC_down1_up2o,
  output logic [2:0]          stepO,
  output logic                busyO,
  output logic                faultO
);

  localparam int CNT_W = (PERIOD_W > DEAD_W) ? PERIOD_W : DEAD_W;
  localparam logic [1:0] PH_OFF = 2'd0;
  localparam logic [1:0] PH_LO  = 2'd1;
  localparam logic [1:0] PH_HI  = 2'd2;

  typedef enum logic [1:0] {IDLE, DEAD, DRIVE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_dead_load, w_per_load;
  logic [2:0]       r_step, w_step_nxt, w_step_inc, w_step_dec;
  logic             r_fault, w_fault_nxt, r_busy;
  logic [1:0]       r_pha, r_phb, r_phc;
  logic [5:0]       w_ph_nxt;
  logic             w_hi_on;

  // Counters hold (interval - 1); a zero setting still yields one clock.
  assign w_dead_load = (deadTimeI == '0)   ? '0 : CNT_W'(deadTimeI - DEAD_W'(1));
  assign w_per_load  = (stepPeriodI == '0) ? '0 : CNT_W'(stepPeriodI - PERIOD_W'(1));
  assign w_step_inc  = (r_step == 3'd5) ? 3'd0 : r_step + 3'd1;
  assign w_step_dec  = (r_step == 3'd0) ? 3'd5 : r_step - 3'd1;

`ifdef MOTOR3_PWM_EN
  logic [7:0] r_pwm;
  // Each DRIVE clock consumes one counter value, so duty 255 gives 255/256 on.
  assign w_hi_on = (r_pwm < pwmDutyI);
  always_ff @(posedge clkI) begin
    if (rstI)                      r_pwm <= '0;
    else if (w_state_nxt == DRIVE) r_pwm <= r_pwm + 8'd1;
  end
`else
  logic w_unused_duty;
  assign w_unused_duty = ^pwmDutyI;
  assign w_hi_on       = 1'b1;
`endif

  // Packed {A,B,C} command for a step; hi_on gates only the high side.
  function automatic logic [5:0] f_phase(input logic [2:0] step, input logic hi_on);
    logic [1:0] hi;
    hi = hi_on ? PH_HI : PH_OFF;
    case (step)
      3'd0:    f_phase = {hi, PH_LO, PH_OFF};
      3'd1:    f_phase = {hi, PH_OFF, PH_LO};
      3'd2:    f_phase = {PH_OFF, hi, PH_LO};
      3'd3:    f_phase = {PH_LO, hi, PH_OFF};
      3'd4:    f_phase = {PH_LO, PH_OFF, hi};
      3'd5:    f_phase = {PH_OFF, PH_LO, hi};
      default: f_phase = '0;
    endcase
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = r_step;
    w_fault_nxt = r_fault;
    if (faultI) begin
      w_fault_nxt = 1'b1;
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (!enI || r_fault) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = DEAD;
          w_cnt_nxt   = w_dead_load;
        end
        DEAD: begin
          if (r_cnt == '0) begin
            w_state_nxt = DRIVE;
            w_cnt_nxt   = w_per_load;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        DRIVE: begin
          if (r_cnt == '0) begin
            w_state_nxt = DEAD;
            w_cnt_nxt   = w_dead_load;
            w_step_nxt  = dirI ? w_step_inc : w_step_dec;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
    w_ph_nxt = (w_state_nxt == DRIVE) ? f_phase(w_step_nxt, w_hi_on) : '0;
  end

  // Outputs are registered from the next-state decode, alongside the state.
  always_ff @(posedge clkI) begin
    if (rstI) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_step  <= '0;
      r_fault <= 1'b0;
      r_busy  <= 1'b0;
      r_pha   <= PH_OFF;
      r_phb   <= PH_OFF;
      r_phc   <= PH_OFF;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_fault <= w_fault_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_pha   <= w_ph_nxt[5:4];
      r_phb   <= w_ph_nxt[3:2];
      r_phc   <= w_ph_nxt[1:0];
    end
  end

  assign phA_down1_up2o = r_pha;
  assign phB_down1_up2o = r_phb;
  assign phC_down1_up2o = r_phc;
  assign stepO          = r_step;
  assign busyO          = r_busy;
  assign faultO         = r_fault;

endmodule

// File: tb/tb_motor3_commutation_sequencer.sv
// Bench for the commutation sequencer: vector table with a scoreboard queue,
// a phase-transition monitor, and PWM duty-window counting.
module tb_motor3_commutation_sequencer;

  logic        clk = 1'b0;
  logic        rst, en, dir, flt;
  logic [15:0] per;
  logic [7:0]  dead, duty;
  logic [1:0]  pa, pb, pc;
  logic [2:0]  step;
  logic        busy, fo;

  always #5 clk = ~clk;

  motor3_commutation_sequencer #(.PERIOD_W(16), .DEAD_W(8)) dut (
    .clkI(clk), .rstI(rst), .enI(en), .dirI(dir), .faultI(flt),
    .stepPeriodI(per), .deadTimeI(dead), .pwmDutyI(duty),
    .phA_down1_up2o(pa), .phB_down1_up2o(pb), .phC_down1_up2o(pc),
    .stepO(step), .busyO(busy), .faultO(fo)
  );

  typedef struct {
    logic        rst, en, dir, flt;
    logic [7:0]  dead;
    logic [15:0] per;
    logic [1:0]  a, b, c;
    logic [2:0]  step;
    logic        busy, fault;
  } vec_t;

  typedef struct packed {
    logic [1:0] a, b, c;
    logic [2:0] step;
    logic       busy, fault;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   glitches = 0;

  logic        s_rst, s_en, s_dir, s_flt;
  logic [7:0]  s_dead;
  logic [15:0] s_per;

`ifdef MOTOR3_PWM_EN
  localparam int HI64 = 64, HI0 = 0, HI255 = 255;
`else
  localparam int HI64 = 256, HI0 = 256, HI255 = 256;
`endif

  // {A,B,C} commutation table: 2 = high side, 1 = low side.
  function automatic logic [5:0] ref_ph(input logic [2:0] s);
    case (s)
      3'd0:    ref_ph = 6'b10_01_00;
      3'd1:    ref_ph = 6'b10_00_01;
      3'd2:    ref_ph = 6'b00_10_01;
      3'd3:    ref_ph = 6'b01_10_00;
      3'd4:    ref_ph = 6'b01_00_10;
      3'd5:    ref_ph = 6'b00_01_10;
      default: ref_ph = 6'b00_00_00;
    endcase
  endfunction

  task automatic add(input logic [5:0] ph, input logic [2:0] st, input logic b, input logic f);
    vec_t v;
    v.rst = s_rst; v.en = s_en; v.dir = s_dir; v.flt = s_flt;
    v.dead = s_dead; v.per = s_per;
    v.a = ph[5:4]; v.b = ph[3:2]; v.c = ph[1:0];
    v.step = st; v.busy = b; v.fault = f;
    vecs.push_back(v);
  endtask

  task automatic off(input logic [2:0] st);                  add(6'd0, st, 1'b1, 1'b0); endtask
  task automatic drv(input logic [2:0] st);                  add(ref_ph(st), st, 1'b1, 1'b0); endtask
  task automatic idle(input logic [2:0] st, input logic f);  add(6'd0, st, 1'b0, f); endtask

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e, g;
    rst = v.rst; en = v.en; dir = v.dir; flt = v.flt; dead = v.dead; per = v.per;
    e.a = v.a; e.b = v.b; e.c = v.c; e.step = v.step; e.busy = v.busy; e.fault = v.fault;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    g.a = pa; g.b = pb; g.c = pc; g.step = step; g.busy = busy; g.fault = fo;
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL vec%0d got a=%0d b=%0d c=%0d step=%0d busy=%0b fault=%0b want a=%0d b=%0d c=%0d step=%0d busy=%0b fault=%0b",
               idx, g.a, g.b, g.c, g.step, g.busy, g.fault, e.a, e.b, e.c, e.step, e.busy, e.fault);
    end
  endtask

  // Counts DRIVE clocks with A high, and any clock where the low side B/C is off-pattern.
  task automatic window(output int hi, output int bad);
    hi = 0; bad = 0;
    repeat (256) begin
      @(posedge clk); #1;
      if (pa == 2'd2) hi++;
      else if (pa != 2'd0) bad++;
      if (pb != 2'd1 || pc != 2'd0) bad++;
    end
  endtask

  // Never code 3, never a direct high<->low flip on any phase.
  logic [5:0] mon_prev = '0;
  logic [5:0] mon_cur;
  initial forever begin
    @(posedge clk); #1;
    mon_cur = {pa, pb, pc};
    for (int k = 0; k < 3; k++) begin
      if (mon_cur[2*k +: 2] == 2'd3 ||
          (mon_prev[2*k +: 2] == 2'd2 && mon_cur[2*k +: 2] == 2'd1) ||
          (mon_prev[2*k +: 2] == 2'd1 && mon_cur[2*k +: 2] == 2'd2))
        glitches++;
    end
    mon_prev = mon_cur;
  end

  initial begin
    int hi, bad;
    rst = 1'b1; en = 1'b0; dir = 1'b1; flt = 1'b0; dead = 8'd2; per = 16'd4; duty = 8'd255;

    // Forward rotation, dead 2 / period 4, full cycle and wrap; reset beats fault
    s_rst = 1; s_en = 1; s_dir = 1; s_flt = 1; s_dead = 8'd2; s_per = 16'd4;
    idle(3'd0, 1'b0);
    s_rst = 0; s_flt = 0;
    for (int s = 0; s < 6; s++) begin
      off(3'(s)); off(3'(s));
      drv(3'(s)); drv(3'(s)); drv(3'(s)); drv(3'(s));
    end
    off(3'd0); off(3'd0); drv(3'd0);

    // Reverse from 0 lands on 5; period change applies next interval; dir sampled at boundary
    s_rst = 1; s_en = 0; s_dir = 0;
    idle(3'd0, 1'b0);
    s_rst = 0; s_en = 1;
    off(3'd0); off(3'd0); drv(3'd0);
    s_per = 16'd2;
    drv(3'd0); drv(3'd0); drv(3'd0);
    off(3'd5); off(3'd5); drv(3'd5);
    s_dir = 1;
    drv(3'd5);
    off(3'd0); off(3'd0); drv(3'd0); drv(3'd0); off(3'd1);

    // Fault latch, enable drop, reset mid-DRIVE
    s_rst = 1; s_per = 16'd4;
    idle(3'd0, 1'b0);
    s_rst = 0;
    off(3'd0); off(3'd0); drv(3'd0); drv(3'd0);
    s_flt = 1; idle(3'd0, 1'b1);
    s_flt = 0; idle(3'd0, 1'b1); idle(3'd0, 1'b1); idle(3'd0, 1'b1);
    s_rst = 1; idle(3'd0, 1'b0);
    s_rst = 0;
    off(3'd0); off(3'd0); drv(3'd0); drv(3'd0);
    s_en = 0; idle(3'd0, 1'b0);
    s_en = 1;
    off(3'd0); off(3'd0); drv(3'd0); drv(3'd0); drv(3'd0); drv(3'd0);
    off(3'd1); off(3'd1); drv(3'd1);
    s_rst = 1; s_flt = 1; idle(3'd0, 1'b0);
    s_rst = 0; s_flt = 0; s_en = 0; idle(3'd0, 1'b0);

    // Zero dead time and zero period: one off clock, one drive clock per step
    s_rst = 1; s_dead = 8'd0; s_per = 16'd0;
    idle(3'd0, 1'b0);
    s_rst = 0; s_en = 1;
    for (int s = 0; s < 6; s++) begin
      off(3'(s)); drv(3'(s));
    end
    off(3'd0); drv(3'd0);

    foreach (vecs[i]) apply(vecs[i], i);

    // PWM duty windows over one 1024-clock DRIVE interval on step 0
    rst = 1; en = 0; flt = 0;
    @(posedge clk); #1;
    rst = 0; en = 1; dir = 1; dead = 8'd0; per = 16'd1024; duty = 8'd64;
    @(posedge clk); #1;
    check("pwm_entry", int'({busy, pa, pb, pc}), 64);
    window(hi, bad);
    check("pwm64_w0", hi, HI64);
    check("pwm64_lo0", bad, 0);
    window(hi, bad);
    check("pwm64_w1", hi, HI64);
    check("pwm64_lo1", bad, 0);
    duty = 8'd0;
    window(hi, bad);
    check("pwm0", hi, HI0);
    check("pwm0_lo", bad, 0);
    duty = 8'd255;
    window(hi, bad);
    check("pwm255", hi, HI255);
    check("pwm255_lo", bad, 0);
    @(posedge clk); #1;
    check("pwm_end_step", int'(step), 1);

    check("no_glitch", glitches, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
